emulador_teclado: RTL

Synthesizable 4x4 matrix-keypad emulator for hardware-in-the-loop and self-test of the keypad scanning path. It plays the keypad's role on the keypad interface: it observes the active-low row drive from the scanner and pulls the matching active-low column line when an emulated key is closed. Key presses are requested over a valid/ready command port, and each press is replayed with configurable contact bounce, hold time and release gap.

---
 rtl/teclado_pkg.sv | 43 ++++
 rtl/generador_rebote.sv | 48 ++++
 rtl/emulador_teclado.sv | 125 ++++++++++++
 3 files changed

// File: rtl/teclado_pkg.sv
// Shared types for the keypad emulator: FSM states, key-to-matrix mapping and idle column level.
package teclado_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_PRESS,
        HOLD,
        BOUNCE_RELEASE,
        GAP
    } emu_state_t;

    typedef struct packed {
        logic [1:0] fila;
        logic [1:0] col;
    } key_pos_t;

    localparam logic [3:0] COL_IDLE = 4'hF;

    // Physical keypad layout; the scanner decodes with the same table.
    function automatic key_pos_t key_pos(input logic [3:0] key);
        key_pos_t p;
        case (key)
            4'h1: p = '{fila: 2'd0, col: 2'd0};
            4'h2: p = '{fila: 2'd0, col: 2'd1};
            4'h3: p = '{fila: 2'd0, col: 2'd2};
            4'hA: p = '{fila: 2'd0, col: 2'd3};
            4'h4: p = '{fila: 2'd1, col: 2'd0};
            4'h5: p = '{fila: 2'd1, col: 2'd1};
            4'h6: p = '{fila: 2'd1, col: 2'd2};
            4'hB: p = '{fila: 2'd1, col: 2'd3};
            4'h7: p = '{fila: 2'd2, col: 2'd0};
            4'h8: p = '{fila: 2'd2, col: 2'd1};
            4'h9: p = '{fila: 2'd2, col: 2'd2};
            4'hC: p = '{fila: 2'd2, col: 2'd3};
            4'hE: p = '{fila: 2'd3, col: 2'd0};
            4'h0: p = '{fila: 2'd3, col: 2'd1};
            4'hF: p = '{fila: 2'd3, col: 2'd2};
            default: p = '{fila: 2'd3, col: 2'd3};  // 4'hD
        endcase
        return p;
    endfunction

endpackage

// File: rtl/generador_rebote.sv
// Phase timer and contact level generator: a plain countdown phase, or a bounce
// phase of BOUNCE_TOGGLES segments of BOUNCE_PERIOD cycles with the level inverting between them.
module generador_rebote #(
    parameter int unsigned BOUNCE_PERIOD  = 2000,
    parameter int unsigned BOUNCE_TOGGLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        carga,
    input  logic        rebote,
    input  logic        nivel_ini,
    input  logic [23:0] longitud,
    output logic        nivel,
    output logic        fin,
    output logic        fin_prox
);

    localparam int unsigned TW = (BOUNCE_TOGGLES == 0) ? 1 : $clog2(BOUNCE_TOGGLES + 1);
    localparam logic [23:0] SEG_INI = 24'(BOUNCE_PERIOD - 1);
    localparam logic [TW-1:0] TOG_INI = TW'((BOUNCE_TOGGLES == 0) ? 0 : BOUNCE_TOGGLES - 1);

    logic [23:0]   cnt;
    logic [TW-1:0] tog;

    // tog holds the segments still to come after the current one, so the
    // toggle that would land on the phase boundary is left to the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            tog   <= '0;
            nivel <= 1'b0;
        end else if (carga) begin
            cnt   <= rebote ? SEG_INI : longitud;
            tog   <= rebote ? TOG_INI : '0;
            nivel <= nivel_ini;
        end else if (cnt != '0) begin
            cnt <= cnt - 24'd1;
        end else if (tog != '0) begin
            tog   <= tog - TW'(1);
            cnt   <= SEG_INI;
            nivel <= ~nivel;
        end
    end

    assign fin      = (cnt == '0) && (tog == '0);
    assign fin_prox = (cnt == 24'd1) && (tog == '0);

endmodule

// File: rtl/emulador_teclado.sv
// 4x4 keypad emulator: replays commanded key presses with bounce, hold and
// release gap, closing the matching column combinationally against the row drive.
module emulador_teclado
    import teclado_pkg::*;
#(
    parameter int unsigned BOUNCE_PERIOD  = 2000,
    parameter int unsigned BOUNCE_TOGGLES = 4,
    parameter int unsigned GAP_CYCLES     = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  filas,
    output logic [3:0]  columnas,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [23:0] cmd_hold,
    output logic        busy,
    output logic        done
);

    localparam logic [23:0] GAP_INI = 24'(GAP_CYCLES - 1);

    emu_state_t  state, next;
    logic [3:0]  key_q;
    logic [23:0] hold_q;
    logic [23:0] hold_in;
    logic        accept, carga, rebote, nivel_ini, contacto, fin, fin_prox, done_nxt;
    logic [23:0] longitud;
    key_pos_t    pos;

    assign accept  = cmd_valid & cmd_ready;
    assign hold_in = (cmd_hold == '0) ? 24'd1 : cmd_hold;

    always_comb begin
        next      = state;
        carga     = 1'b0;
        rebote    = 1'b0;
        nivel_ini = 1'b0;
        longitud  = '0;
        case (state)
            IDLE: if (accept) begin
                carga     = 1'b1;
                nivel_ini = 1'b1;
                if (BOUNCE_TOGGLES == 0) begin
                    next     = HOLD;
                    longitud = hold_in - 24'd1;
                end else begin
                    next   = BOUNCE_PRESS;
                    rebote = 1'b1;
                end
            end
            BOUNCE_PRESS: if (fin) begin
                next      = HOLD;
                carga     = 1'b1;
                nivel_ini = 1'b1;
                longitud  = hold_q - 24'd1;
            end
            HOLD: if (fin) begin
                carga = 1'b1;
                if (BOUNCE_TOGGLES == 0) begin
                    next     = GAP;
                    longitud = GAP_INI;
                end else begin
                    next   = BOUNCE_RELEASE;
                    rebote = 1'b1;
                end
            end
            BOUNCE_RELEASE: if (fin) begin
                next     = GAP;
                carga    = 1'b1;
                longitud = GAP_INI;
            end
            GAP: if (fin) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // done is registered, so it is raised one cycle ahead of the last GAP cycle.
    assign done_nxt = (next == GAP) &&
                      ((state != GAP && GAP_CYCLES == 1) || (state == GAP && fin_prox));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_q     <= '0;
            hold_q    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next;
            cmd_ready <= (next == IDLE);
            busy      <= (next != IDLE);
            done      <= done_nxt;
            if (accept) begin
                key_q  <= cmd_key;
                hold_q <= hold_in;
            end
        end
    end

    generador_rebote #(
        .BOUNCE_PERIOD (BOUNCE_PERIOD),
        .BOUNCE_TOGGLES(BOUNCE_TOGGLES)
    ) u_rebote (
        .clk      (clk),
        .rst_n    (rst_n),
        .carga    (carga),
        .rebote   (rebote),
        .nivel_ini(nivel_ini),
        .longitud (longitud),
        .nivel    (contacto),
        .fin      (fin),
        .fin_prox (fin_prox)
    );

    assign pos = key_pos(key_q);

    always_comb begin
        columnas = COL_IDLE;
        if (contacto && !filas[pos.fila]) columnas[pos.col] = 1'b0;
    end

endmodule
